// File: rtl/mem_scheduler_pkg.sv
// Shared types and constants for the memory request scheduler and its store buffer.
package mem_scheduler_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int BLOCK_SIZE = 2;
    localparam int BLOCK_BITS = 32 * BLOCK_SIZE;
    localparam int SB_WIDTH   = 2;
    localparam int SB_DEPTH   = 1 << SB_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] IO_BASE = 32'h0003_0000;
    localparam logic [SB_WIDTH:0]     SB_FULL_COUNT = (SB_WIDTH + 1)'(SB_DEPTH);

    localparam logic [2:0] WIDTH_BYTE = 3'd1;
    localparam logic [2:0] WIDTH_HALF = 3'd2;
    localparam logic [2:0] WIDTH_WORD = 3'd4;

    typedef enum logic [1:0] {
        OWN_FETCH = 2'd0,
        OWN_LOAD  = 2'd1,
        OWN_DRAIN = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            width;
        logic [31:0]           data;
    } sb_entry_t;

    // Rotation order fetch -> load -> drain -> fetch.
    function automatic owner_e next_owner(input owner_e o);
        case (o)
            OWN_FETCH: return OWN_LOAD;
            OWN_LOAD:  return OWN_DRAIN;
            default:   return OWN_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mem_scheduler_store_buffer.sv
// In-order posted-store FIFO with a combinational load-conflict check against every live entry.
module mem_store_buffer
    import mem_scheduler_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rdy_i,
    input  logic                  push_i,
    input  sb_entry_t             push_entry_i,
    input  logic                  pop_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    output sb_entry_t             head_o,
    output logic [SB_WIDTH:0]     count_o,
    output logic                  full_o,
    output logic                  conflict_o
);

    localparam logic [SB_WIDTH-1:0] PTR_ONE = SB_WIDTH'(1);
    localparam logic [SB_WIDTH:0]   CNT_ONE = (SB_WIDTH + 1)'(1);

    sb_entry_t             entries_q [SB_DEPTH];
    logic [SB_WIDTH-1:0]   head_q;
    logic [SB_WIDTH-1:0]   tail_q;
    logic [SB_WIDTH:0]     count_q;
    logic [SB_WIDTH:0]     count_d;
    logic                  full_q;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic                  match_s;
    logic                  io_block_s;
    logic [SB_WIDTH-1:0]   offs_s;

    assign push_ok_s = push_i && !full_q;
    assign pop_ok_s  = pop_i && (|count_q);

    always_comb begin
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (rdy_i) begin
            if (push_ok_s) begin
                tail_q <= tail_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                head_q <= head_q + PTR_ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == SB_FULL_COUNT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && rdy_i && push_ok_s) begin
            entries_q[tail_q] <= push_entry_i;
        end
    end

    // An entry is live when its distance from head is below count; only live entries may block a load.
    always_comb begin
        match_s = 1'b0;
        offs_s  = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            offs_s = SB_WIDTH'(i) - head_q;
            if (({1'b0, offs_s} < count_q) &&
                (entries_q[i].addr[ADDR_WIDTH-1:2] == ld_addr_i[ADDR_WIDTH-1:2])) begin
                match_s = 1'b1;
            end else begin
                match_s = match_s;
            end
        end
    end

    assign io_block_s = (ld_addr_i >= IO_BASE) && (|count_q);
    assign conflict_o = match_s || io_block_s;
    assign head_o     = entries_q[head_q];
    assign count_o    = count_q;
    assign full_o     = full_q;

endmodule

// File: rtl/mem_scheduler.sv
// Arbitrates fetch, load and store-drain requests onto a single-ported memory controller
// and routes each completion back to its owner.
module mem_scheduler
    import mem_scheduler_pkg::*;
(
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    input  logic                  RoB_clear,
    input  logic                  ICMS_en,
    input  logic [ADDR_WIDTH-1:0] ICMS_addr,
    output logic                  MSIC_en,
    output logic [BLOCK_BITS-1:0] MSIC_block,
    input  logic                  LDMS_en,
    input  logic [ADDR_WIDTH-1:0] LDMS_addr,
    input  logic [2:0]            LDMS_width,
    output logic                  MSLD_en,
    output logic [31:0]           MSLD_data,
    input  logic                  STMS_en,
    input  logic [ADDR_WIDTH-1:0] STMS_addr,
    input  logic [2:0]            STMS_width,
    input  logic [31:0]           STMS_data,
    output logic                  MSST_full,
    output logic                  MSMC_ic,
    output logic                  MSMC_en,
    output logic                  MSMC_wr,
    output logic [2:0]            MSMC_width,
    output logic [ADDR_WIDTH-1:0] MSMC_addr,
    output logic [31:0]           MSMC_data,
    input  logic                  MCMS_r_en,
    input  logic                  MCMS_w_en,
    input  logic                  MCMS_ic_en,
    input  logic [31:0]           MCMS_data,
    input  logic [BLOCK_BITS-1:0] MCMS_block
);

    state_e                state_q;
    owner_e                rr_q;
    owner_e                owner_q;
    owner_e                winner_s;
    owner_e                cand_s;
    logic                  valid_q;
    logic                  discard_q;
    logic                  discard_d;
    logic                  req_ic_q;
    logic                  req_wr_q;
    logic [2:0]            req_width_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [31:0]           req_data_q;
    logic                  msic_en_q;
    logic [BLOCK_BITS-1:0] msic_block_q;
    logic                  msld_en_q;
    logic [31:0]           msld_data_q;

    sb_entry_t             sb_push_s;
    sb_entry_t             sb_head_s;
    logic [SB_WIDTH:0]     sb_count_s;
    logic                  sb_full_s;
    logic                  sb_conflict_s;
    logic                  sb_pop_s;
    logic                  done_s;
    logic                  grant_s;
    logic [2:0]            elig_s;

    assign sb_push_s = {STMS_addr, STMS_width, STMS_data};
    assign sb_pop_s  = done_s && (owner_q == OWN_DRAIN);

    mem_store_buffer u_sb (
        .clk_i        (Sys_clk),
        .rst_i        (Sys_rst),
        .rdy_i        (Sys_rdy),
        .push_i       (STMS_en),
        .push_entry_i (sb_push_s),
        .pop_i        (sb_pop_s),
        .ld_addr_i    (LDMS_addr),
        .head_o       (sb_head_s),
        .count_o      (sb_count_s),
        .full_o       (sb_full_s),
        .conflict_o   (sb_conflict_s)
    );

    always_comb begin
        done_s = 1'b0;
        if (state_q == ST_BUSY) begin
            case (owner_q)
                OWN_FETCH: done_s = MCMS_ic_en;
                OWN_LOAD:  done_s = MCMS_r_en;
                OWN_DRAIN: done_s = MCMS_w_en;
                default:   done_s = 1'b0;
            endcase
        end else begin
            done_s = 1'b0;
        end
    end

    assign discard_d = discard_q || (RoB_clear && (owner_q != OWN_DRAIN));
    assign elig_s    = {(|sb_count_s), (LDMS_en && !sb_conflict_s), ICMS_en};

    // A full buffer forces a drain; otherwise scan three slots starting at the rotating pointer.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = OWN_FETCH;
        cand_s   = rr_q;
        if (sb_full_s) begin
            grant_s  = 1'b1;
            winner_s = OWN_DRAIN;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!grant_s && elig_s[cand_s]) begin
                    grant_s  = 1'b1;
                    winner_s = cand_s;
                end else begin
                    grant_s  = grant_s;
                end
                cand_s = next_owner(cand_s);
            end
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            state_q      <= ST_IDLE;
            rr_q         <= OWN_FETCH;
            owner_q      <= OWN_FETCH;
            valid_q      <= 1'b0;
            discard_q    <= 1'b0;
            req_ic_q     <= 1'b0;
            req_wr_q     <= 1'b0;
            req_width_q  <= 3'd0;
            req_addr_q   <= '0;
            req_data_q   <= 32'h0;
            msic_en_q    <= 1'b0;
            msic_block_q <= '0;
            msld_en_q    <= 1'b0;
            msld_data_q  <= 32'h0;
        end else if (Sys_rdy) begin
            msic_en_q <= 1'b0;
            msld_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_q   <= ST_BUSY;
                        valid_q   <= 1'b1;
                        owner_q   <= winner_s;
                        rr_q      <= next_owner(winner_s);
                        discard_q <= 1'b0;
                        case (winner_s)
                            OWN_FETCH: begin
                                req_ic_q    <= 1'b1;
                                req_wr_q    <= 1'b0;
                                req_width_q <= WIDTH_WORD;
                                req_addr_q  <= ICMS_addr;
                                req_data_q  <= 32'h0;
                            end
                            OWN_LOAD: begin
                                req_ic_q    <= 1'b0;
                                req_wr_q    <= 1'b0;
                                req_width_q <= LDMS_width;
                                req_addr_q  <= LDMS_addr;
                                req_data_q  <= 32'h0;
                            end
                            default: begin
                                req_ic_q    <= 1'b0;
                                req_wr_q    <= 1'b1;
                                req_width_q <= sb_head_s.width;
                                req_addr_q  <= sb_head_s.addr;
                                req_data_q  <= sb_head_s.data;
                            end
                        endcase
                    end
                end
                ST_BUSY: begin
                    discard_q <= discard_d;
                    if (done_s) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                        if ((owner_q == OWN_FETCH) && !discard_d) begin
                            msic_en_q    <= 1'b1;
                            msic_block_q <= MCMS_block;
                        end
                        if ((owner_q == OWN_LOAD) && !discard_d) begin
                            msld_en_q   <= 1'b1;
                            msld_data_q <= MCMS_data;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Drop the request the instant its completion arrives so the controller never re-samples it.
    assign MSMC_en    = valid_q && !(MCMS_r_en || MCMS_w_en || MCMS_ic_en);
    assign MSMC_ic    = req_ic_q;
    assign MSMC_wr    = req_wr_q;
    assign MSMC_width = req_width_q;
    assign MSMC_addr  = req_addr_q;
    assign MSMC_data  = req_data_q;
    assign MSIC_en    = msic_en_q;
    assign MSIC_block = msic_block_q;
    assign MSLD_en    = msld_en_q;
    assign MSLD_data  = msld_data_q;
    assign MSST_full  = sb_full_s;

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed bench for mem_scheduler with a queue-based behavioural model checked every cycle.
module tb_mem_scheduler;
    import mem_scheduler_pkg::*;

    localparam int BW = BLOCK_BITS;

    logic          Sys_clk;
    logic          Sys_rst, Sys_rdy, RoB_clear;
    logic          ICMS_en;
    logic [31:0]   ICMS_addr;
    logic          MSIC_en;
    logic [BW-1:0] MSIC_block;
    logic          LDMS_en;
    logic [31:0]   LDMS_addr;
    logic [2:0]    LDMS_width;
    logic          MSLD_en;
    logic [31:0]   MSLD_data;
    logic          STMS_en;
    logic [31:0]   STMS_addr;
    logic [2:0]    STMS_width;
    logic [31:0]   STMS_data;
    logic          MSST_full;
    logic          MSMC_ic, MSMC_en, MSMC_wr;
    logic [2:0]    MSMC_width;
    logic [31:0]   MSMC_addr, MSMC_data;
    logic          MCMS_r_en, MCMS_w_en, MCMS_ic_en;
    logic [31:0]   MCMS_data;
    logic [BW-1:0] MCMS_block;

    mem_scheduler dut (
        .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy), .RoB_clear(RoB_clear),
        .ICMS_en(ICMS_en), .ICMS_addr(ICMS_addr), .MSIC_en(MSIC_en), .MSIC_block(MSIC_block),
        .LDMS_en(LDMS_en), .LDMS_addr(LDMS_addr), .LDMS_width(LDMS_width),
        .MSLD_en(MSLD_en), .MSLD_data(MSLD_data),
        .STMS_en(STMS_en), .STMS_addr(STMS_addr), .STMS_width(STMS_width), .STMS_data(STMS_data),
        .MSST_full(MSST_full), .MSMC_ic(MSMC_ic), .MSMC_en(MSMC_en), .MSMC_wr(MSMC_wr),
        .MSMC_width(MSMC_width), .MSMC_addr(MSMC_addr), .MSMC_data(MSMC_data),
        .MCMS_r_en(MCMS_r_en), .MCMS_w_en(MCMS_w_en), .MCMS_ic_en(MCMS_ic_en),
        .MCMS_data(MCMS_data), .MCMS_block(MCMS_block)
    );

    initial Sys_clk = 1'b0;
    always #5 Sys_clk = ~Sys_clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  width;
        logic [31:0] data;
    } st_t;

    // Model state: pending stores, who owns the controller, rotation pointer, last outputs.
    st_t           m_sb[$];
    bit            m_busy;
    int            m_owner;
    int            m_rr;
    bit            m_disc;
    logic          m_ic, m_wr;
    logic [2:0]    m_width;
    logic [31:0]   m_addr, m_wdata;
    logic          m_icp, m_ldp;
    logic [BW-1:0] m_block;
    logic [31:0]   m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sb.delete();
        m_busy = 1'b0; m_owner = 0; m_rr = 0; m_disc = 1'b0;
        m_ic = 1'b0; m_wr = 1'b0; m_width = 3'd0; m_addr = 32'h0; m_wdata = 32'h0;
        m_icp = 1'b0; m_ldp = 1'b0; m_block = '0; m_data = 32'h0;
    endtask

    // Advance the model by one clock using the inputs the coming posedge will sample.
    task automatic model_step();
        bit full_pre;
        bit done;
        bit blocked;
        int win;
        if (Sys_rst) begin
            model_reset();
            return;
        end
        if (!Sys_rdy) return;
        full_pre = (m_sb.size() == 4);
        m_icp = 1'b0;
        m_ldp = 1'b0;
        if (m_busy) begin
            if (RoB_clear && m_owner != 2) m_disc = 1'b1;
            done = (m_owner == 0 && MCMS_ic_en) || (m_owner == 1 && MCMS_r_en) ||
                   (m_owner == 2 && MCMS_w_en);
            if (done) begin
                m_busy = 1'b0;
                if (m_owner == 0 && !m_disc) begin m_icp = 1'b1; m_block = MCMS_block; end
                if (m_owner == 1 && !m_disc) begin m_ldp = 1'b1; m_data = MCMS_data; end
                if (m_owner == 2) void'(m_sb.pop_front());
            end
        end else begin
            blocked = (LDMS_addr >= 32'h0003_0000) && (m_sb.size() != 0);
            foreach (m_sb[i]) if (m_sb[i].addr[31:2] == LDMS_addr[31:2]) blocked = 1'b1;
            win = -1;
            if (full_pre) win = 2;
            else begin
                for (int k = 0; k < 3; k++) begin
                    int c;
                    c = (m_rr + k) % 3;
                    if (win < 0 && ((c == 0 && ICMS_en) || (c == 1 && LDMS_en && !blocked) ||
                                    (c == 2 && m_sb.size() != 0))) win = c;
                end
            end
            if (win >= 0) begin
                m_busy = 1'b1; m_owner = win; m_rr = (win + 1) % 3; m_disc = 1'b0;
                if (win == 0) begin
                    m_ic = 1'b1; m_wr = 1'b0; m_width = 3'd4; m_addr = ICMS_addr; m_wdata = 32'h0;
                end else if (win == 1) begin
                    m_ic = 1'b0; m_wr = 1'b0; m_width = LDMS_width; m_addr = LDMS_addr; m_wdata = 32'h0;
                end else begin
                    m_ic = 1'b0; m_wr = 1'b1; m_width = m_sb[0].width;
                    m_addr = m_sb[0].addr; m_wdata = m_sb[0].data;
                end
            end
        end
        if (STMS_en && !full_pre) m_sb.push_back('{STMS_addr, STMS_width, STMS_data});
    endtask

    // Compare on the falling edge, then step the model toward the next rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge Sys_clk);
            if (check_en) begin
                chk("MSST_full", 64'(MSST_full), 64'(m_sb.size() == 4));
                chk("MSMC_en", 64'(MSMC_en),
                    64'(m_busy && !(MCMS_r_en || MCMS_w_en || MCMS_ic_en)));
                chk("MSMC_ic", 64'(MSMC_ic), 64'(m_ic));
                chk("MSMC_wr", 64'(MSMC_wr), 64'(m_wr));
                chk("MSMC_width", 64'(MSMC_width), 64'(m_width));
                chk("MSMC_addr", 64'(MSMC_addr), 64'(m_addr));
                chk("MSMC_data", 64'(MSMC_data), 64'(m_wdata));
                chk("MSIC_en", 64'(MSIC_en), 64'(m_icp));
                chk("MSIC_block", MSIC_block, m_block);
                chk("MSLD_en", 64'(MSLD_en), 64'(m_ldp));
                chk("MSLD_data", 64'(MSLD_data), 64'(m_data));
            end
            model_step();
        end
    end

    task automatic cyc();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic wait_mc(input string name);
        int n;
        n = 0;
        while (!MSMC_en && n < 60) begin cyc(); n++; end
        checks++;
        if (!MSMC_en) begin
            errors++;
            $display("FAIL %s: no downstream request within 60 cycles", name);
        end
    endtask

    task automatic respond(input logic [31:0] d, input logic [BW-1:0] b);
        cyc();
        cyc();
        MCMS_data = d;
        MCMS_block = b;
        if (MSMC_wr) MCMS_w_en = 1'b1;
        else if (MSMC_ic) MCMS_ic_en = 1'b1;
        else MCMS_r_en = 1'b1;
        cyc();
        MCMS_w_en = 1'b0; MCMS_ic_en = 1'b0; MCMS_r_en = 1'b0;
    endtask

    task automatic wait_ld(input string name, input logic [31:0] exp);
        int n;
        n = 0;
        while (!MSLD_en && n < 20) begin cyc(); n++; end
        chk({name, " pulse"}, 64'(MSLD_en), 64'h1);
        chk({name, " data"}, 64'(MSLD_data), 64'(exp));
        LDMS_en = 1'b0;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d);
        STMS_en = 1'b1; STMS_addr = a; STMS_width = 3'd4; STMS_data = d;
        cyc();
        STMS_en = 1'b0;
    endtask

    task automatic do_reset();
        Sys_rst = 1'b1;
        cyc();
        Sys_rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_ic [3];
        logic [31:0] exp_drain [3];
        int seen;
        exp_ic = '{1'b1, 1'b0, 1'b1};
        exp_drain = '{32'h3020, 32'h3030, 32'h3100};
        Sys_rst = 1'b1; Sys_rdy = 1'b1; RoB_clear = 1'b0;
        ICMS_en = 1'b0; ICMS_addr = 32'h0;
        LDMS_en = 1'b0; LDMS_addr = 32'h0; LDMS_width = 3'd0;
        STMS_en = 1'b0; STMS_addr = 32'h0; STMS_width = 3'd0; STMS_data = 32'h0;
        MCMS_r_en = 1'b0; MCMS_w_en = 1'b0; MCMS_ic_en = 1'b0;
        MCMS_data = 32'h0; MCMS_block = '0;
        cyc();
        cyc();
        Sys_rst = 1'b0;
        check_en = 1'b1;
        chk("reset MSMC_en", 64'(MSMC_en), 64'h0);
        chk("reset MSST_full", 64'(MSST_full), 64'h0);

        // Load to the same word as a buffered store waits for the drain.
        push_store(32'h1000, 32'hDEAD_BEEF);
        LDMS_en = 1'b1; LDMS_addr = 32'h1002; LDMS_width = 3'd4;
        wait_mc("s1 drain");
        chk("s1 drain first", {MSMC_wr, MSMC_addr}, {31'h0, 1'b1, 32'h1000});
        chk("s1 drain data", 64'(MSMC_data), 64'hDEAD_BEEF);
        respond(32'h0, '0);
        wait_mc("s1 load");
        chk("s1 load issued", {MSMC_wr, MSMC_addr}, {31'h0, 1'b0, 32'h1002});
        respond(32'h1122_3344, '0);
        wait_ld("s1 load", 32'h1122_3344);

        // Fetch and load held together alternate starting with fetch.
        do_reset();
        ICMS_en = 1'b1; ICMS_addr = 32'h400;
        LDMS_en = 1'b1; LDMS_addr = 32'h2000; LDMS_width = 3'd4;
        for (int i = 0; i < 3; i++) begin
            wait_mc("s2 grant");
            chk("s2 grant order", 64'(MSMC_ic), 64'(exp_ic[i]));
            respond(32'h100 + 32'(i), 64'hB10C_0000_0000_0000 + 64'(i));
        end
        chk("s2 last fetch pulse", 64'(MSIC_en), 64'h1);
        chk("s2 last fetch block", MSIC_block, 64'hB10C_0000_0000_0002);
        ICMS_en = 1'b0; LDMS_en = 1'b0;
        cyc();

        // Fill the buffer behind a stalled drain, then check full priority.
        do_reset();
        for (int i = 0; i < 5; i++) push_store(32'h3000 + 32'(16 * i), 32'hA0 + 32'(i));
        chk("s3 full", 64'(MSST_full), 64'h1);
        ICMS_en = 1'b1; ICMS_addr = 32'h800;
        wait_mc("s3 first drain");
        chk("s3 first drain addr", 64'(MSMC_addr), 64'h3000);
        respond(32'h0, '0);
        chk("s3 full clears", 64'(MSST_full), 64'h0);
        push_store(32'h3100, 32'h55);
        wait_mc("s3 fetch");
        chk("s3 fetch granted", 64'(MSMC_ic), 64'h1);
        respond(32'h0, 64'h1234);
        wait_mc("s3 drain over fetch");
        chk("s3 drain beats fetch", {MSMC_wr, MSMC_addr}, {31'h0, 1'b1, 32'h3010});
        ICMS_en = 1'b0;
        respond(32'h0, '0);
        for (int i = 0; i < 3; i++) begin
            wait_mc("s3 drain rest");
            chk("s3 drain order", 64'(MSMC_addr), 64'(exp_drain[i]));
            respond(32'h0, '0);
        end

        // Frozen pushes are ignored; an MMIO load waits for an empty buffer.
        do_reset();
        Sys_rdy = 1'b0;
        STMS_en = 1'b1; STMS_addr = 32'h9000; STMS_width = 3'd4; STMS_data = 32'h1;
        cyc();
        cyc();
        STMS_en = 1'b0;
        Sys_rdy = 1'b1;
        push_store(32'h2000, 32'h77);
        LDMS_en = 1'b1; LDMS_addr = 32'h0003_0000; LDMS_width = 3'd1;
        wait_mc("s4 drain");
        chk("s4 drain addr", 64'(MSMC_addr), 64'h2000);
        repeat (4) cyc();
        respond(32'h0, '0);
        wait_mc("s4 io load");
        chk("s4 io load", {MSMC_wr, MSMC_width, MSMC_addr}, {28'h0, 1'b0, 3'd1, 32'h0003_0000});
        respond(32'h5A, '0);
        wait_ld("s4 io load", 32'h5A);

        // Flush during an owned fetch suppresses its completion pulse.
        do_reset();
        ICMS_en = 1'b1; ICMS_addr = 32'h440;
        wait_mc("s5 fetch");
        RoB_clear = 1'b1; ICMS_en = 1'b0;
        cyc();
        RoB_clear = 1'b0;
        respond(32'h0, 64'hFACE);
        seen = 0;
        repeat (4) begin
            if (MSIC_en) seen++;
            cyc();
        end
        chk("s5 no fetch pulse", 64'(seen), 64'h0);
        LDMS_en = 1'b1; LDMS_addr = 32'h500; LDMS_width = 3'd2;
        wait_mc("s5 idle again");
        chk("s5 load after flush", 64'(MSMC_addr), 64'h500);
        respond(32'h99, '0);
        wait_ld("s5 load", 32'h99);

        // Reset mid-drain discards the transaction and the buffer.
        do_reset();
        push_store(32'h4000, 32'h11);
        push_store(32'h4010, 32'h22);
        wait_mc("s6 drain");
        Sys_rst = 1'b1;
        cyc();
        Sys_rst = 1'b0;
        chk("s6 outputs cleared", {MSMC_en, MSMC_wr, MSMC_ic, MSST_full, MSIC_en, MSLD_en, MSMC_addr},
            64'h0);
        seen = 0;
        repeat (6) begin
            if (MSMC_en || MSIC_en || MSLD_en) seen++;
            cyc();
        end
        chk("s6 stores lost", 64'(seen), 64'h0);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_scheduler.md
Name: mem_scheduler

Overview:
Request scheduler placed between the core's memory clients (ICache fetch, LSB load, LSB store) and the single-ported MemController. Stores are posted into a small in-order store buffer and drained in the background. Loads are held back only on an address conflict with a buffered store. A rotating-priority arbiter issues one request at a time downstream and routes each completion back to its owner.

Parameters:
ADDR_WIDTH, 32, address width
BLOCK_SIZE, 2, instructions per ICache block; response block is 32*BLOCK_SIZE bits
SB_WIDTH, 2, log2 of store-buffer depth (4 entries)
IO_BASE, 32'h30000, addresses >= this are MMIO

Ports:
Sys_clk  in  1  clock
Sys_rst  in  1  synchronous active-high reset
Sys_rdy  in  1  global enable; all state frozen when 0
RoB_clear  in  1  misprediction flush
ICMS_en  in  1  fetch request, held until MSIC_en
ICMS_addr  in  ADDR_WIDTH  fetch block address
MSIC_en  out  1  one-cycle fetch completion pulse
MSIC_block  out  32*BLOCK_SIZE  fetched block
LDMS_en  in  1  load request, held until MSLD_en
LDMS_addr  in  ADDR_WIDTH  load address
LDMS_width  in  3  1/2/4 bytes
MSLD_en  out  1  one-cycle load completion pulse
MSLD_data  out  32  raw load data (zero-extended)
STMS_en  in  1  store push, accepted when !MSST_full
STMS_addr  in  ADDR_WIDTH  store address
STMS_width  in  3  1/2/4 bytes
STMS_data  in  32  store data
MSST_full  out  1  store buffer full
MSMC_ic  out  1  downstream request is a fetch
MSMC_en  out  1  downstream request valid
MSMC_wr  out  1  1 = write
MSMC_width  out  3  access width
MSMC_addr  out  ADDR_WIDTH  access address
MSMC_data  out  32  write data
MCMS_r_en  in  1  downstream read-done pulse
MCMS_w_en  in  1  downstream write-done pulse
MCMS_ic_en  in  1  downstream fetch-done pulse
MCMS_data  in  32  load result
MCMS_block  in  32*BLOCK_SIZE  fetch result

Behaviour:
- Reset (Sys_rst at posedge): state IDLE; store buffer emptied (head = tail = count = 0); rr pointer = fetch. All outputs 0. A reset mid-transaction abandons the transaction and produces no completion pulse.
- Sys_rdy = 0: no state change and no pulses generated; outputs hold.
- Store buffer: circular FIFO of {addr, width, data}.
  - Push on STMS_en && !MSST_full.
  - Pop when MCMS_w_en ends a store transaction.
  - A simultaneous push and pop keeps count unchanged.
  - MSST_full = (count == 2^SB_WIDTH) and is registered.
  - Head/tail wrap modulo depth.
  - RoB_clear never touches the buffer; stores are already committed.
- Load conflict: a load is blocked if any valid entry satisfies entry.addr[31:2] == LDMS_addr[31:2]. It is also blocked if LDMS_addr >= IO_BASE and count != 0.
- States: IDLE, BUSY.
- IDLE arbitration. Eligible requesters are: fetch (ICMS_en), load (LDMS_en && !blocked), drain (count != 0).
  - If MSST_full, drain wins outright.
  - Otherwise the first eligible requester in rotating order starting at rr wins. Order is fetch -> load -> drain -> fetch.
  - After a grant, rr = winner + 1.
  - The winner's fields are latched into the MSMC_* registers, a request-valid register is set, the owner is recorded, and the state goes to BUSY.
  - Latency: request visible at IDLE posedge -> MSMC_en high the next cycle.
- MSMC_en = valid_q && !(MCMS_r_en || MCMS_w_en || MCMS_ic_en). This gating is combinational so the controller never re-samples a finished request.
- BUSY: hold MSMC_* stable.
  - On the completion pulse matching the owner: clear valid and return to IDLE.
  - Next posedge: drive MSIC_en/MSLD_en high for exactly 1 cycle with the registered MCMS_block/MCMS_data.
  - Minimum spacing between grants is 1 IDLE cycle.
- RoB_clear: while an owned load or fetch is in BUSY, set a discard flag. The transaction still runs to completion, but no MSLD_en/MSIC_en pulse is produced. Pending unissued loads and fetches simply drop their en. A clear during a drain has no effect.
- A load blocked behind a matching store becomes eligible in the cycle after that entry pops.

Decomposition:
- Shared package: ADDR_WIDTH, BLOCK_SIZE, IO_BASE, width codes (BYTE=1, HALF=2, WORD=4), owner encoding (FETCH=0, LOAD=1, DRAIN=2), state encoding.
- Sub-module: mem_store_buffer (FIFO plus combinational conflict compare, exporting head entry, count, full, conflict).

Test Plan:
- Store 0x1000 width 4 data 0xDEADBEEF, then load 0x1002: load is held until MCMS_w_en for the store; MSMC then issues read 0x1002, and MSLD_en pulses once with MCMS_data.
- ICMS_en and LDMS_en held together (no stores), rr = fetch: grants are fetch, load, fetch in alternation; each MSIC_en/MSLD_en is exactly 1 cycle wide.
- Push 4 stores with the downstream stalled: MSST_full = 1 and the 5th push is ignored. Drain wins over a pending fetch; after one MCMS_w_en, count = 3 and full = 0 the next cycle.
- Load 0x30000 with 1 buffered store to 0x2000: the load is blocked until the buffer is empty, then issued.
- Fetch granted, RoB_clear pulsed in BUSY: MCMS_ic_en arrives, no MSIC_en is produced, and the scheduler returns to IDLE.
- Sys_rst asserted in BUSY with 2 buffered stores: next cycle all outputs are 0, MSST_full = 0, and the stores are lost with no pulses.
